cdb_result_buffer: RTL and testbench
====================================

CDB_RESULT_BUFFER -- requirements
Module: cdb_result_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, result entries held (power of 2, >= 2).
REQ-002 The block SHALL have parameter TAG_WIDTH, default 5, CDB tag width.
REQ-003 The block SHALL have port clk  input  1  single clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port flush  input  1  discard all buffered results.
REQ-006 The block SHALL have port fu_valid  input  1  FU result present this cycle.
REQ-007 The block SHALL have port fu_data  input  32  FU result value.
REQ-008 The block SHALL have port fu_tag  input  TAG_WIDTH  FU destination tag.
REQ-009 The block SHALL have port fu_exception  input  1  FU exception flag.
REQ-010 The block SHALL have port fu_ready  output  1  buffer can accept a result this cycle.
REQ-011 The block SHALL have port req  output  1  CDB request (producer req bit).
REQ-012 The block SHALL have port data_in  output  32  head result value to CDB.
REQ-013 The block SHALL have port tag_in  output  TAG_WIDTH  head result tag to CDB.
REQ-014 The block SHALL have port exception_in  output  1  head result exception to CDB.
REQ-015 The block SHALL have port grant  input  1  same-cycle CDB grant for this producer.
REQ-016 The block SHALL have port count  output  $clog2(DEPTH)+1  entries currently held.

Function
REQ-017 The block SHALL be an in-order FIFO: results leave on the CDB in the order accepted.
REQ-018 The block SHALL accept a push when fu_valid && fu_ready; fu_ready SHALL equal (count != DEPTH), with no pop-dependent ready when full.
REQ-019 The block SHALL drive req = (count != 0), and data_in/tag_in/exception_in from the head entry, all decoded from registered state.
REQ-020 A pop SHALL occur at the rising edge where req && grant; grant without req SHALL be ignored.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 The pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0; full/empty SHALL derive from count.
REQ-023 The write-to-req latency SHALL be one cycle (result pushed at edge N drives req in cycle N+1).
REQ-024 When count is 0, data_in/tag_in/exception_in SHALL be don't-care but stable (head entry contents).
REQ-025 flush SHALL take priority over push and pop: at that edge count, read and write pointers SHALL become 0, and any same-cycle push or grant SHALL be discarded.
REQ-026 req SHALL stay asserted with unchanged head until granted (no drop, no reorder).

Reset
REQ-027 While rst_n is low: count=0, pointers=0, req=0, and fu_ready SHALL be 1 once rst_n is high.
REQ-028 Storage contents SHALL NOT be reset; reset SHALL take effect immediately, mid-operation included, with all held results lost.

Configuration
REQ-029 With macro CDB_RB_BYPASS_EN defined: when count==0 and fu_valid, req SHALL be 1 and data_in/tag_in/exception_in SHALL be the fu_* inputs that same cycle; if granted, the entry SHALL NOT be written, otherwise it SHALL be pushed normally.
REQ-030 Without CDB_RB_BYPASS_EN: no fu_*->req combinational path SHALL exist, and REQ-023 latency SHALL apply.

Structure
REQ-031 Package cdb_pkg SHALL hold the CDB_TAG_WIDTH and CDB_DATA_WIDTH (32) constants and the typedef cdb_result_t {data, tag, exception}.
REQ-032 Storage SHALL be an array of cdb_result_t; the pointer/count logic SHALL be one sub-module, cdb_rb_ctrl.

Verification
REQ-033 Test 1: push 0xA5A5_0001 with tag 3, grant held high -> req=1 in the next cycle with tag_in=3; popped at that edge; count back to 0.
REQ-034 Test 2: push 4 results with grant=0 -> fu_ready=0 and count=4; one grant -> fu_ready=1 in the next cycle; outputs in order 1,2,3,4.
REQ-035 Test 3: count=2 with push and grant in the same cycle -> count stays 2, head advances, pointer wraps correctly after 8 such cycles.
REQ-036 Test 4: count=3, flush together with push and grant -> count=0, req=0 in the next cycle, nothing emitted.
REQ-037 Test 5: assert rst_n low mid-stream with count=2 -> req=0 and count=0 immediately, without waiting for a clock edge.
REQ-038 Test 6 (CDB_RB_BYPASS_EN): empty, fu_valid with tag 7 and grant=1 -> req=1 and tag_in=7 in the same cycle; count stays 0.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared CDB constants and the result record carried by the result buffer.
package cdb_pkg;

   localparam int CDB_DATA_WIDTH = 32;
   localparam int CDB_TAG_WIDTH  = 5;

   // One functional-unit result waiting for the common data bus
   typedef struct packed {
      logic [CDB_DATA_WIDTH-1:0] data;
      logic [CDB_TAG_WIDTH-1:0]  tag;
      logic                      exception;
   } cdb_result_t;

endpackage

// File: rtl/cdb_rb_ctrl.sv
// Pointer and occupancy control for the CDB result buffer.
// Full/empty come from the occupancy count; pointers wrap naturally
// because DEPTH is a power of two.
module cdb_rb_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push_req,
   input  logic                       pop_req,
   output logic                       wr_en,
   output logic [$clog2(DEPTH)-1:0]   wr_ptr,
   output logic [$clog2(DEPTH)-1:0]   rd_ptr,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       not_full,
   output logic                       not_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic push;
   logic pop;

   // Qualify requests against occupancy; flush cancels both
   always_comb begin
      not_full  = (count != CW'(DEPTH));
      not_empty = (count != '0);
      push      = push_req && not_full && !flush;
      pop       = pop_req && not_empty && !flush;
      wr_en     = push;
   end

   // Pointer and count state; flush beats any same-cycle push or pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: rtl/cdb_result_buffer.sv
// In-order result FIFO between one functional unit and the CDB arbiter.
// Optional macro CDB_RB_BYPASS_EN: when the buffer is empty, a valid FU
// result is offered to the CDB in the same cycle and is only stored if
// it is not granted. Without the macro every result spends at least one
// cycle in storage, so req depends only on registered state.
module cdb_result_buffer
   import cdb_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int TAG_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     fu_valid,
   input  logic [31:0]              fu_data,
   input  logic [TAG_WIDTH-1:0]     fu_tag,
   input  logic                     fu_exception,
   output logic                     fu_ready,
   output logic                     req,
   output logic [31:0]              data_in,
   output logic [TAG_WIDTH-1:0]     tag_in,
   output logic                     exception_in,
   input  logic                     grant,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   cdb_result_t storage [DEPTH];
   cdb_result_t wr_entry;
   cdb_result_t head;

   logic          wr_en;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          not_full;
   logic          not_empty;
   logic          bypass_take;

   // A bypassed result that wins the bus this cycle must not also be stored
   always_comb begin
`ifdef CDB_RB_BYPASS_EN
      bypass_take = !not_empty && fu_valid && grant;
`else
      bypass_take = 1'b0;
`endif
      wr_entry.data      = fu_data;
      wr_entry.tag       = CDB_TAG_WIDTH'(fu_tag);
      wr_entry.exception = fu_exception;
   end

   cdb_rb_ctrl #(
      .DEPTH (DEPTH)
   ) u_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push_req  (fu_valid && !bypass_take),
      .pop_req   (grant),
      .wr_en     (wr_en),
      .wr_ptr    (wr_ptr),
      .rd_ptr    (rd_ptr),
      .count     (count),
      .not_full  (not_full),
      .not_empty (not_empty)
   );

   // Result storage is deliberately left unreset; only valid entries are ever read out
   always_ff @(posedge clk) begin
      if (wr_en) storage[wr_ptr] <= wr_entry;
   end

   // CDB request and head presentation, from stored state or the bypass path
   always_comb begin
      head         = storage[rd_ptr];
      fu_ready     = not_full;
      req          = not_empty;
      data_in      = head.data;
      tag_in       = TAG_WIDTH'(head.tag);
      exception_in = head.exception;
`ifdef CDB_RB_BYPASS_EN
      if (!not_empty && fu_valid) begin
         req          = 1'b1;
         data_in      = fu_data;
         tag_in       = fu_tag;
         exception_in = fu_exception;
      end
`endif
   end

endmodule

// File: tb/tb_cdb_result_buffer.sv
// Self-checking bench for cdb_result_buffer: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based model of the buffer.
module tb_cdb_result_buffer;
   import cdb_pkg::*;

   localparam int DEPTH     = 4;
   localparam int TAG_WIDTH = 5;

   logic                   clk;
   logic                   rst_n;
   logic                   flush;
   logic                   fu_valid;
   logic [31:0]            fu_data;
   logic [TAG_WIDTH-1:0]   fu_tag;
   logic                   fu_exception;
   logic                   fu_ready;
   logic                   req;
   logic [31:0]            data_in;
   logic [TAG_WIDTH-1:0]   tag_in;
   logic                   exception_in;
   logic                   grant;
   logic [$clog2(DEPTH):0] count;

   int checks   = 0;
   int failures = 0;

   cdb_result_t q[$];
   cdb_result_t newEntry;
   bit modelByp;
   bit modelPop;
   bit modelPush;
   bit expByp;

   cdb_result_buffer #(
      .DEPTH     (DEPTH),
      .TAG_WIDTH (TAG_WIDTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .fu_valid     (fu_valid),
      .fu_data      (fu_data),
      .fu_tag       (fu_tag),
      .fu_exception (fu_exception),
      .fu_ready     (fu_ready),
      .req          (req),
      .data_in      (data_in),
      .tag_in       (tag_in),
      .exception_in (exception_in),
      .grant        (grant),
      .count        (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [TAG_WIDTH-1:0] t,
                                input logic e, input logic g, input logic f);
      fu_valid     = v;
      fu_data      = d;
      fu_tag       = t;
      fu_exception = e;
      grant        = g;
      flush        = f;
   endtask

   // Reference model: a plain queue of accepted results
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else if (flush) begin
         q.delete();
      end else begin
         modelByp = 1'b0;
`ifdef CDB_RB_BYPASS_EN
         modelByp = (q.size() == 0) && fu_valid && grant;
`endif
         modelPop  = (q.size() != 0) && grant;
         modelPush = fu_valid && (q.size() != DEPTH) && !modelByp;
         newEntry.data      = fu_data;
         newEntry.tag       = fu_tag;
         newEntry.exception = fu_exception;
         if (modelPop)  void'(q.pop_front());
         if (modelPush) q.push_back(newEntry);
      end
   end

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         expByp = 1'b0;
`ifdef CDB_RB_BYPASS_EN
         expByp = (q.size() == 0) && fu_valid;
`endif
         checkOutput("req", 32'(req), 32'((q.size() != 0) || expByp));
         checkOutput("fu_ready", 32'(fu_ready), 32'(q.size() != DEPTH));
         checkOutput("count", 32'(count), 32'(q.size()));
         if (expByp) begin
            checkOutput("bypass_data", data_in, fu_data);
            checkOutput("bypass_tag", 32'(tag_in), 32'(fu_tag));
            checkOutput("bypass_exc", 32'(exception_in), 32'(fu_exception));
         end else if (q.size() != 0) begin
            checkOutput("head_data", data_in, q[0].data);
            checkOutput("head_tag", 32'(tag_in), 32'(q[0].tag));
            checkOutput("head_exc", 32'(exception_in), 32'(q[0].exception));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
      #3;
      checkOutput("reset_req", 32'(req), 32'd0);
      checkOutput("reset_count", 32'(count), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      #1;
      checkOutput("reset_fu_ready", 32'(fu_ready), 32'd1);

      // Test 1: single push with grant held high
      applyStimulus(1'b1, 32'hA5A5_0001, 5'd3, 1'b0, 1'b1, 1'b0);
`ifdef CDB_RB_BYPASS_EN
      #1;
      checkOutput("t1_req_bypass", 32'(req), 32'd1);
      checkOutput("t1_tag_bypass", 32'(tag_in), 32'd3);
      step();
      applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b1, 1'b0);
      checkOutput("t1_count", 32'(count), 32'd0);
`else
      step();
      applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b1, 1'b0);
      checkOutput("t1_req", 32'(req), 32'd1);
      checkOutput("t1_tag", 32'(tag_in), 32'd3);
      checkOutput("t1_data", data_in, 32'hA5A5_0001);
      step();
      checkOutput("t1_count", 32'(count), 32'd0);
      checkOutput("t1_req_after", 32'(req), 32'd0);
`endif

      // Test 2: fill to full, then drain in order
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b1, 32'(k), 5'(k), 1'b0, 1'b0, 1'b0);
         step();
      end
      applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("t2_full_ready", 32'(fu_ready), 32'd0);
      checkOutput("t2_full_count", 32'(count), 32'd4);
      checkOutput("t2_head1", data_in, 32'd1);
      for (int k = 2; k <= 4; k++) begin
         grant = 1'b1;
         step();
         grant = 1'b0;
         checkOutput("t2_ready", 32'(fu_ready), 32'd1);
         checkOutput("t2_head", data_in, 32'(k));
      end
      grant = 1'b1;
      step();
      grant = 1'b0;
      checkOutput("t2_drained", 32'(count), 32'd0);

      // Test 3: steady push+pop at count 2 across pointer wrap
      applyStimulus(1'b1, 32'd10, 5'd10, 1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 32'd11, 5'd11, 1'b0, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 32'(20 + i), 5'(20 + i), 1'b1, 1'b1, 1'b0);
         step();
         checkOutput("t3_count", 32'(count), 32'd2);
         checkOutput("t3_head", data_in, (i == 0) ? 32'd11 : 32'(20 + i - 1));
      end
      applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b1, 1'b0);
      step();
      step();
      grant = 1'b0;
      checkOutput("t3_drained", 32'(count), 32'd0);

      // Test 4: flush beats simultaneous push and grant
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 32'(40 + k), 5'(k), 1'b0, 1'b0, 1'b0);
         step();
      end
      checkOutput("t4_pre_count", 32'(count), 32'd3);
      applyStimulus(1'b1, 32'd99, 5'd9, 1'b0, 1'b1, 1'b1);
      step();
      applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("t4_count", 32'(count), 32'd0);
      checkOutput("t4_req", 32'(req), 32'd0);
      step();
      checkOutput("t4_req_later", 32'(req), 32'd0);

      // Test 5: asynchronous reset mid-stream
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 32'(50 + k), 5'(k), 1'b0, 1'b0, 1'b0);
         step();
      end
      applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("t5_pre_count", 32'(count), 32'd2);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("t5_req", 32'(req), 32'd0);
      checkOutput("t5_count", 32'(count), 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      checkOutput("t5_ready", 32'(fu_ready), 32'd1);

      // Test 6: empty buffer, valid result with grant in the same cycle
      applyStimulus(1'b1, 32'h0000_0777, 5'd7, 1'b0, 1'b1, 1'b0);
      #1;
`ifdef CDB_RB_BYPASS_EN
      checkOutput("t6_req", 32'(req), 32'd1);
      checkOutput("t6_tag", 32'(tag_in), 32'd7);
      step();
      applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("t6_count", 32'(count), 32'd0);
`else
      checkOutput("t6_req_nobypass", 32'(req), 32'd0);
      step();
      applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("t6_count_nobypass", 32'(count), 32'd1);
      checkOutput("t6_tag_nobypass", 32'(tag_in), 32'd7);
      grant = 1'b1;
      step();
      grant = 1'b0;
`endif

      // Randomized traffic against the queue model
      for (int c = 0; c < 3000; c++) begin
         applyStimulus(($urandom_range(0, 9) < 6), $urandom, 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1),
                       ($urandom_range(0, 39) == 0));
         if ($urandom_range(0, 399) == 0) begin
            #2;
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
         end else begin
            step();
         end
      end

      applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
